// File: rtl/tqvp_rejunity_vga_fb.sv
// tqvp_rejunity_vga_fb: scanline-buffer VGA peripheral for the TinyQV bus.
// One line of PIXEL_COUNT pixels (BPP bits each) and a 2^BPP-entry palette,
// shown on every scanline of internally generated 1024x768 timing at 64 MHz.
// Optional macro VGA_FB_READBACK_EN enables the register read mux.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   ui_in           - unused
//   uo_out          - {hsync, rrggbb[5:3], vsync, rrggbb[2:0]}, registered
//   address         - byte address within the peripheral
//   data_in         - write data
//   data_write_n    - 11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n     - same encoding, used only with readback enabled
//   data_out        - combinational read data (0 without readback)
//   data_ready      - always 1
//   user_interrupt  - level line/frame interrupt, cleared by write to 0x3C
module tqvp_rejunity_vga_fb #(
    parameter int PIXEL_COUNT = 320,
    parameter int BPP         = 1,
    parameter int PIXEL_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int LINE_BITS = PIXEL_COUNT * BPP;
    localparam int WORDS     = LINE_BITS / 32;
    localparam int NPAL      = 1 << BPP;
    localparam int IW        = $clog2(LINE_BITS);
    localparam int PW_W      = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;

    localparam logic [10:0] H_ACT      = 11'd1024;
    localparam logic [10:0] H_SYNC_BEG = 11'd1048;
    localparam logic [10:0] H_SYNC_END = 11'd1184;
    localparam logic [10:0] H_LAST     = 11'd1343;
    localparam logic [9:0]  V_ACT      = 10'd768;
    localparam logic [9:0]  V_SYNC_BEG = 10'd771;
    localparam logic [9:0]  V_SYNC_END = 10'd777;
    localparam logic [9:0]  V_LAST     = 10'd805;

    logic [10:0]          hcount;
    logic [9:0]           vcount;
    logic [PW_W-1:0]      presc;
    logic [10:0]          pix_idx;
    logic [LINE_BITS-1:0] line_q;
    logic [5:0]           pal_q [NPAL];
    logic [1:0]           ctrl_q;

    logic                 active;
    logic                 hsync_n;
    logic                 vsync_n;
    logic [IW-1:0]        bit_idx;
    logic [BPP-1:0]       pix_val;
    logic [5:0]           rgb;

    logic                 wr;
    logic                 line_we;
    logic                 pal_we;
    logic                 ctrl_we;
    logic                 irq_set;
    logic                 irq_clr;

    logic                 unused;
    assign unused = &{1'b0, ui_in, data_read_n};

    assign data_ready = 1'b1;

    function automatic logic [5:0] pal_reset(input int n);
        case (n)
            0:       return 6'h10;
            1:       return 6'h0B;
            2:       return 6'h3F;
            default: return 6'h00;
        endcase
    endfunction

    // Beam counters. The pixel prescaler is realigned at the start of
    // every line so pixel n always begins at hcount n*PIXEL_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount  <= '0;
            vcount  <= '0;
            presc   <= '0;
            pix_idx <= '0;
        end else if (hcount == H_LAST) begin
            hcount  <= '0;
            vcount  <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
            presc   <= '0;
            pix_idx <= '0;
        end else begin
            hcount <= hcount + 11'd1;
            if (presc == PW_W'(PIXEL_WIDTH - 1)) begin
                presc   <= '0;
                pix_idx <= pix_idx + 11'd1;
            end else begin
                presc <= presc + PW_W'(1);
            end
        end
    end

    always_comb begin
        active  = (hcount < H_ACT) && (vcount < V_ACT);
        hsync_n = !((hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END));
        vsync_n = !((vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END));
        bit_idx = IW'(pix_idx * 11'(BPP));
        pix_val = line_q[bit_idx +: BPP];
        rgb     = 6'h00;
        if (active && ctrl_q[0]) begin
            // Past the last stored pixel the line is padded with PAL[0].
            if (pix_idx >= 11'(PIXEL_COUNT)) begin
                rgb = pal_q[0];
            end else begin
                rgb = pal_q[pix_val];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= 8'h88;
        end else begin
            uo_out <= {hsync_n, rgb[5:3], vsync_n, rgb[2:0]};
        end
    end

    always_comb begin
        wr      = (data_write_n != 2'b11);
        line_we = wr && (data_write_n == 2'b10) &&
                  (address[1:0] == 2'b00) &&
                  (address[5:2] < 4'(WORDS));
        pal_we  = wr && (address[5:2] == 4'hC);
        ctrl_we = wr && (address == 6'h38);
        irq_clr = wr && (address == 6'h3C);
        if (ctrl_q[1]) begin
            irq_set = (vcount == V_ACT) && (hcount == 11'd0);
        end else begin
            irq_set = (hcount == H_ACT) && (vcount < V_ACT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q         <= '0;
            ctrl_q         <= 2'b01;
            user_interrupt <= 1'b0;
            for (int n = 0; n < NPAL; n++) begin
                pal_q[n] <= pal_reset(n);
            end
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (line_we && (address[5:2] == 4'(w))) begin
                    line_q[32*w +: 32] <= data_in;
                end
            end
            for (int n = 0; n < NPAL; n++) begin
                if (pal_we && (address[1:0] == 2'(n))) begin
                    pal_q[n] <= data_in[5:0];
                end
            end
            if (ctrl_we) begin
                ctrl_q <= data_in[1:0];
            end
            // A set event beats a simultaneous clear.
            if (irq_set) begin
                user_interrupt <= 1'b1;
            end else if (irq_clr) begin
                user_interrupt <= 1'b0;
            end
        end
    end

`ifdef VGA_FB_READBACK_EN
    logic vblank;
    assign vblank = (vcount >= V_ACT);

    always_comb begin
        data_out = 32'h0;
        if (data_read_n != 2'b11) begin
            for (int w = 0; w < WORDS; w++) begin
                if (address == 6'(4 * w)) begin
                    data_out = line_q[32*w +: 32];
                end
            end
            for (int n = 0; n < NPAL; n++) begin
                if (address == 6'(48 + n)) begin
                    data_out = {26'b0, pal_q[n]};
                end
            end
            if (address == 6'h38) begin
                data_out = {30'b0, ctrl_q};
            end
            if (address == 6'h3C) begin
                data_out = {vblank, 21'b0, vcount};
            end
        end
    end
`else
    assign data_out = 32'h0;
`endif

endmodule

// File: tb/tb_tqvp_rejunity_vga_fb.sv
// Directed bench for tqvp_rejunity_vga_fb: a BPP=1 instance (defaults)
// and a BPP=2 instance, checked against hand-computed uo_out codes.
module tb_tqvp_rejunity_vga_fb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ui_in = 8'h00;
    logic [5:0]  addr1 = 6'h0, addr2 = 6'h0;
    logic [31:0] din1 = 32'h0, din2 = 32'h0;
    logic [1:0]  wn1 = 2'b11, wn2 = 2'b11;
    logic [1:0]  rn1 = 2'b11, rn2 = 2'b11;
    logic [7:0]  uo1, uo2;
    logic [31:0] dout1, dout2;
    logic        rdy1, rdy2, irq1, irq2;

    int total = 0;
    int bad = 0;
    int cyc;

    tqvp_rejunity_vga_fb dut1 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo1),
        .address(addr1), .data_in(din1), .data_write_n(wn1),
        .data_read_n(rn1), .data_out(dout1), .data_ready(rdy1),
        .user_interrupt(irq1)
    );

    tqvp_rejunity_vga_fb #(
        .PIXEL_COUNT(128), .BPP(2), .PIXEL_WIDTH(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo2),
        .address(addr2), .data_in(din2), .data_write_n(wn2),
        .data_read_n(rn2), .data_out(dout2), .data_ready(rdy2),
        .user_interrupt(irq2)
    );

    // Edges since reset release; after edge k, hcount == k mod 1344 and
    // uo_out shows the pixel for hcount k-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef VGA_FB_READBACK_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr1(input logic [5:0] a, input logic [31:0] d,
                       input logic [1:0] w);
        addr1 = a; din1 = d; wn1 = w;
        @(posedge clk);
        #1;
        wn1 = 2'b11;
    endtask

    task automatic wr2(input logic [5:0] a, input logic [31:0] d,
                       input logic [1:0] w);
        addr2 = a; din2 = d; wn2 = w;
        @(posedge clk);
        #1;
        wn2 = 2'b11;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (uo1 !== 8'h88 || uo2 !== 8'h88) begin
            bad++;
            $display("FAIL reset_uo uo1=%h uo2=%h want=88", uo1, uo2);
        end
        total++;
        if (irq1 !== 1'b0 || rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_irq_rdy irq=%b rdy=%b want 0/1", irq1, rdy1);
        end
        addr1 = 6'h38; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== rb(32'h1)) begin
            bad++;
            $display("FAIL reset_ctrl_read got=%h want=%h", dout1, rb(32'h1));
        end
        rn1 = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sync_timing();
        int c [7] = '{1, 1024, 1025, 1048, 1049, 1184, 1185};
        logic [7:0] e [7] = '{8'hA8, 8'hA8, 8'h88, 8'h88, 8'h08, 8'h08, 8'h88};
        for (int i = 0; i < 7; i++) begin
            goto(c[i]);
            total++;
            if (uo1 !== e[i]) begin
                bad++;
                $display("FAIL sync[%0d] cyc=%0d uo=%h want=%h", i, cyc, uo1, e[i]);
            end
            if (c[i] == 1024 || c[i] == 1025) begin
                total++;
                if (irq1 !== (c[i] == 1025)) begin
                    bad++;
                    $display("FAIL irq_line0 cyc=%0d irq=%b", cyc, irq1);
                end
            end
        end
    endtask

    task automatic test_irq_clear();
        goto(1190);
        wr1(6'h3C, 32'h0, 2'b00);
        total++;
        if (irq1 !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear irq=%b want=0", irq1);
        end
    endtask

    task automatic test_line_write();
        int c [9] = '{1345, 1347, 1348, 1441, 2209, 2304, 2305, 2368, 2369};
        logic [7:0] e [9] = '{8'h9B, 8'h9B, 8'hA8, 8'hA8, 8'h9B,
                              8'h9B, 8'hA8, 8'hA8, 8'h88};
        goto(1200);
        wr1(6'h00, 32'h0000_0001, 2'b10);
        wr1(6'h04, 32'h0000_00FF, 2'b00);
        wr1(6'h24, 32'hFFFF_FFFF, 2'b10);
        addr1 = 6'h00; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== rb(32'h1)) begin
            bad++;
            $display("FAIL read_word0 got=%h want=%h", dout1, rb(32'h1));
        end
        addr1 = 6'h04; #1;
        total++;
        if (dout1 !== 32'h0) begin
            bad++;
            $display("FAIL byte_write_word1 got=%h want=0", dout1);
        end
        rn1 = 2'b11;
        for (int i = 0; i < 9; i++) begin
            goto(c[i]);
            total++;
            if (uo1 !== e[i]) begin
                bad++;
                $display("FAIL line1[%0d] cyc=%0d uo=%h want=%h", i, cyc, uo1, e[i]);
            end
        end
    endtask

    task automatic test_bpp2();
        int c [7] = '{2689, 2692, 2695, 2698, 2701, 3072, 3073};
        logic [7:0] e [7] = '{8'hA8, 8'h9B, 8'hFF, 8'h88, 8'hA8, 8'h9B, 8'hA8};
        goto(2380);
        wr2(6'h00, 32'h0000_00E4, 2'b10);
        wr2(6'h1C, 32'h5555_5555, 2'b10);
        for (int i = 0; i < 7; i++) begin
            goto(c[i]);
            total++;
            if (uo2 !== e[i]) begin
                bad++;
                $display("FAIL bpp2[%0d] cyc=%0d uo=%h want=%h", i, cyc, uo2, e[i]);
            end
        end
    endtask

    task automatic test_palette();
        goto(3080);
        wr1(6'h30, 32'hFFFF_FF3F, 2'b00);
        wr1(6'h31, 32'h0000_0003, 2'b01);
        addr1 = 6'h30; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== rb(32'h3F)) begin
            bad++;
            $display("FAIL read_pal0 got=%h want=%h", dout1, rb(32'h3F));
        end
        rn1 = 2'b11;
        goto(4033);
        total++;
        if (uo1 !== 8'h8B) begin
            bad++;
            $display("FAIL pal1_pixel uo=%h want=8b", uo1);
        end
        goto(4036);
        total++;
        if (uo1 !== 8'hFF) begin
            bad++;
            $display("FAIL pal0_pixel uo=%h want=ff", uo1);
        end
    endtask

    task automatic test_irq_collision();
        goto(4040);
        total++;
        if (irq1 !== 1'b1) begin
            bad++;
            $display("FAIL irq_line2 irq=%b want=1", irq1);
        end
        wr1(6'h3C, 32'h0, 2'b10);
        goto(5056);
        total++;
        if (irq1 !== 1'b0) begin
            bad++;
            $display("FAIL irq_pre_collide irq=%b want=0", irq1);
        end
        wr1(6'h3C, 32'h0, 2'b00);
        total++;
        if (irq1 !== 1'b1) begin
            bad++;
            $display("FAIL irq_set_wins irq=%b want=1", irq1);
        end
        wr1(6'h3C, 32'h0, 2'b00);
        total++;
        if (irq1 !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear2 irq=%b want=0", irq1);
        end
    endtask

    task automatic test_enable();
        goto(5070);
        wr1(6'h38, 32'h0, 2'b10);
        addr1 = 6'h38; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== 32'h0) begin
            bad++;
            $display("FAIL read_ctrl0 got=%h want=0", dout1);
        end
        rn1 = 2'b11;
        goto(5377);
        total++;
        if (uo1 !== 8'h88) begin
            bad++;
            $display("FAIL en0_blank uo=%h want=88", uo1);
        end
        goto(6400);
        total++;
        if (irq1 !== 1'b0) begin
            bad++;
            $display("FAIL en0_irq_early irq=%b want=0", irq1);
        end
        goto(6401);
        total++;
        if (irq1 !== 1'b1) begin
            bad++;
            $display("FAIL en0_irq irq=%b want=1", irq1);
        end
    endtask

    task automatic test_mode1();
        goto(6410);
        wr1(6'h3C, 32'h0, 2'b00);
        wr1(6'h38, 32'h3, 2'b10);
        goto(6721);
        total++;
        if (uo1 !== 8'h8B) begin
            bad++;
            $display("FAIL mode1_pixel uo=%h want=8b", uo1);
        end
        goto(6800);
        addr1 = 6'h3C; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== rb(32'h5)) begin
            bad++;
            $display("FAIL read_status got=%h want=%h", dout1, rb(32'h5));
        end
        rn1 = 2'b11;
        goto(7746);
        total++;
        if (irq1 !== 1'b0) begin
            bad++;
            $display("FAIL mode1_no_line_irq irq=%b want=0", irq1);
        end
    endtask

    task automatic test_async_reset();
        goto(7750);
        wr1(6'h38, 32'h1, 2'b10);
        goto(9509);
        total++;
        if (uo1 !== 8'hFF || irq1 !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset uo=%h irq=%b want ff/1", uo1, irq1);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (uo1 !== 8'h88 || uo2 !== 8'h88 || irq1 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset uo1=%h uo2=%h irq=%b", uo1, uo2, irq1);
        end
        #1 rst_n = 1'b1;
        goto(1);
        total++;
        if (uo1 !== 8'hA8 || uo2 !== 8'hA8) begin
            bad++;
            $display("FAIL post_reset uo1=%h uo2=%h want=a8", uo1, uo2);
        end
        addr1 = 6'h38; rn1 = 2'b10; #1;
        total++;
        if (dout1 !== rb(32'h1)) begin
            bad++;
            $display("FAIL post_reset_ctrl got=%h want=%h", dout1, rb(32'h1));
        end
        rn1 = 2'b11;
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_irq_clear();
        test_line_write();
        test_bpp2();
        test_palette();
        test_irq_collision();
        test_enable();
        test_mode1();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
